// File: rtl/bayes_infer_seq_pkg.sv
// Shared widths and state encoding for the inference sequencer.
// The FIFO pointer width is derived here so the top and the FIFO agree on it.
package bayes_infer_seq_pkg;

  localparam int N_FEAT     = 8;
  localparam int FEAT_W     = 4;
  localparam int RES_W      = 8;
  localparam int CNT_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int FEAT_VEC_W = N_FEAT * FEAT_W;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FEAT = 3'd1,
    LOAD      = 3'd2,
    COMPUTE   = 3'd3,
    DRAIN     = 3'd4
  } seq_state_e;

endpackage

// File: rtl/bayes_infer_seq_if.sv
// Feature intake stream and result readout stream of the inference sequencer.
// The slave modport is the sequencer side; the master modport is the host side.
interface bayes_infer_seq_if
  import bayes_infer_seq_pkg::*;
();

  logic                  feat_valid;
  logic                  feat_ready;
  logic [FEAT_VEC_W-1:0] feat_data;
  logic                  res_valid;
  logic                  res_ready;
  logic [RES_W-1:0]      res_data;

  modport slave (
    input  feat_valid, feat_data, res_ready,
    output feat_ready, res_valid, res_data
  );

  modport master (
    output feat_valid, feat_data, res_ready,
    input  feat_ready, res_valid, res_data
  );

endinterface

// File: rtl/bayes_infer_seq_res_fifo.sv
// First-word fall-through result FIFO with flush.
// Pointers carry one extra wrap bit so full and empty are told apart without a separate flag.
module bayes_res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic [W-1:0] mem_r [DEPTH];
  logic         push_ok_s;
  logic         pop_ok_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count     = wr_ptr_r - rd_ptr_r;
  assign head      = mem_r[rd_ptr_r[AW-1:0]];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage and pointer update; flush empties the queue without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/bayes_infer_seq.sv
// Sequences N inference samples through the Bayesian array: feature intake, load strobe,
// compute with optional timeout, and result capture into a FIFO for readout.
module bayes_infer_seq
  import bayes_infer_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [CNT_W-1:0]      n_samples_i,
  input  logic [CNT_W-1:0]      timeout_i,
  bayes_infer_seq_if.slave      bus,
  output logic [FEAT_VEC_W-1:0] chip_feat_o,
  output logic                  chip_load_o,
  output logic                  chip_compute_o,
  input  logic                  chip_done_i,
  input  logic [RES_W-1:0]      chip_result_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_timeout_o,
  output logic                  aborted_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [FIFO_AW:0] FIFO_NONE = {(FIFO_AW+1){1'b0}};

  seq_state_e            state_r;
  logic [CNT_W-1:0]      remain_r;
  logic [CNT_W-1:0]      timer_r;
  logic [CNT_W-1:0]      timeout_r;
  logic [FEAT_VEC_W-1:0] feat_r;
  logic                  load_r;
  logic                  compute_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;
  logic                  aborted_r;

  logic                  abort_s;
  logic                  accept_s;
  logic                  push_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [FIFO_AW:0]      fifo_count_s;

  // Intake is refused when the FIFO has no free slot, so a later capture always fits.
  assign abort_s        = abort_i && (state_r != IDLE);
  assign accept_s       = (state_r == WAIT_FEAT) && !fifo_full_s && !abort_i;
  assign push_s         = (state_r == COMPUTE) && chip_done_i && !abort_i;
  assign bus.feat_ready = accept_s;
  assign bus.res_valid  = !fifo_empty_s;

  assign chip_feat_o    = feat_r;
  assign chip_load_o    = load_r;
  assign chip_compute_o = compute_r;
  assign busy_o         = busy_r;
  assign done_o         = done_r;
  assign err_timeout_o  = err_r;
  assign aborted_o      = aborted_r;

  bayes_res_fifo #(
    .W     (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort_s),
    .push      (push_s),
    .push_data (chip_result_i),
    .pop       (bus.res_ready),
    .head      (bus.res_data),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Run-control FSM with all array strobes and status flags registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      remain_r  <= CNT_ZERO;
      timer_r   <= CNT_ZERO;
      timeout_r <= CNT_ZERO;
      feat_r    <= {FEAT_VEC_W{1'b0}};
      load_r    <= 1'b0;
      compute_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      load_r <= 1'b0;
      done_r <= 1'b0;
      if (abort_s) begin
        state_r   <= IDLE;
        compute_r <= 1'b0;
        busy_r    <= 1'b0;
        aborted_r <= 1'b1;
        done_r    <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            if (start_i) begin
              err_r     <= 1'b0;
              aborted_r <= 1'b0;
              if (n_samples_i == CNT_ZERO) begin
                done_r <= 1'b1;
              end else begin
                state_r   <= WAIT_FEAT;
                busy_r    <= 1'b1;
                remain_r  <= n_samples_i;
                timeout_r <= timeout_i;
              end
            end
          end
          WAIT_FEAT: begin
            if (accept_s && bus.feat_valid) begin
              feat_r  <= bus.feat_data;
              load_r  <= 1'b1;
              state_r <= LOAD;
            end
          end
          LOAD: begin
            timer_r   <= timeout_r;
            compute_r <= 1'b1;
            state_r   <= COMPUTE;
          end
          COMPUTE: begin
            // A done arriving on the expiry cycle still counts as a good sample.
            if (chip_done_i) begin
              remain_r  <= remain_r - CNT_ONE;
              compute_r <= 1'b0;
              state_r   <= (remain_r == CNT_ONE) ? DRAIN : WAIT_FEAT;
            end else if (timeout_r != CNT_ZERO) begin
              timer_r <= timer_r - CNT_ONE;
              if (timer_r == CNT_ONE) begin
                err_r     <= 1'b1;
                compute_r <= 1'b0;
                state_r   <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (fifo_count_s == FIFO_NONE) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
          default: begin
            state_r   <= IDLE;
            compute_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bayes_infer_seq.sv
// Directed bench for bayes_infer_seq with a behavioural array model answering 5 cycles after load.
module tb_bayes_infer_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        abort_i;
  logic [15:0] n_samples_i;
  logic [15:0] timeout_i;
  logic [31:0] chip_feat_o;
  logic        chip_load_o;
  logic        chip_compute_o;
  logic        chip_done_i;
  logic [7:0]  chip_result_i;
  logic        busy_o;
  logic        done_o;
  logic        err_timeout_o;
  logic        aborted_o;

  bayes_infer_seq_if bus ();

  bayes_infer_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .n_samples_i    (n_samples_i),
    .timeout_i      (timeout_i),
    .bus            (bus),
    .chip_feat_o    (chip_feat_o),
    .chip_load_o    (chip_load_o),
    .chip_compute_o (chip_compute_o),
    .chip_done_i    (chip_done_i),
    .chip_result_i  (chip_result_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_timeout_o  (err_timeout_o),
    .aborted_o      (aborted_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Feature source: word k is the nibble k replicated, advancing on each handshake.
  logic [3:0] feat_idx = 4'h0;
  always @(posedge clk) begin
    if (bus.feat_valid && bus.feat_ready) feat_idx <= feat_idx + 4'h1;
  end
  assign bus.feat_data = {8{feat_idx}};

  // Array model: result = low feature byte + 3, done pulse 5 cycles after load.
  logic       chip_en;
  int         cd;
  logic [7:0] mdl_res;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd            <= 0;
      chip_done_i   <= 1'b0;
      chip_result_i <= 8'h00;
      mdl_res       <= 8'h00;
    end else begin
      chip_done_i <= 1'b0;
      if (abort_i) begin
        cd <= 0;
      end else if (chip_load_o && chip_en) begin
        cd      <= 5;
        mdl_res <= chip_feat_o[7:0] + 8'h03;
      end else if (cd == 1) begin
        chip_done_i   <= 1'b1;
        chip_result_i <= mdl_res;
        cd            <= 0;
      end else if (cd > 0) begin
        cd <= cd - 1;
      end
    end
  end

  int          load_cnt, comp_cnt, done_cnt, pops_at_done, lat_bad;
  bit          busy_seen, done_d;
  logic [7:0]  pop_q[$];
  logic [31:0] feat_q[$];

  // Monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (chip_load_o) begin
      load_cnt++;
      feat_q.push_back(chip_feat_o);
    end
    if (chip_compute_o) comp_cnt++;
    if (busy_o) busy_seen = 1'b1;
    if (done_o) begin
      done_cnt++;
      pops_at_done = pop_q.size();
    end
    if (bus.res_valid && bus.res_ready) pop_q.push_back(bus.res_data);
    if (done_d && !bus.res_valid) lat_bad++;
    done_d = chip_done_i && !abort_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    load_cnt = 0; comp_cnt = 0; done_cnt = 0; pops_at_done = -1; lat_bad = 0;
    busy_seen = 1'b0;
    pop_q.delete();
    feat_q.delete();
  endtask

  task automatic pulse_start(input logic [15:0] n, input logic [15:0] to);
    n_samples_i = n;
    timeout_i   = to;
    start_i     = 1'b1;
    step(1);
    start_i     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    base = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != base) break;
      step(1);
    end
    chk(tag, done_cnt - base, 1);
  endtask

  task automatic wait_compute(input string tag, input int loads, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (load_cnt >= loads && chip_compute_o) begin
        seen = 1'b1;
        break;
      end
      step(1);
    end
    chk(tag, seen, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    n_samples_i = 16'd0; timeout_i = 16'd0;
    bus.feat_valid = 1'b0; bus.res_ready = 1'b1; chip_en = 1'b1;
    clear_mon();
    step(2);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_load", chip_load_o, 1'b0);
    chk("rst_compute", chip_compute_o, 1'b0);
    chk("rst_feat", chip_feat_o, 32'h0);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_feat_ready", bus.feat_ready, 1'b0);
    chk("rst_err", err_timeout_o, 1'b0);
    chk("rst_aborted", aborted_o, 1'b0);
    rst_n = 1'b1;
    bus.feat_valid = 1'b1;
    step(2);

    // Normal run of 3 samples, no timeout, results drained immediately.
    clear_mon();
    pulse_start(16'd3, 16'd0);
    wait_done("n3_done", 200);
    step(2);
    chk("n3_loads", load_cnt, 3);
    chk("n3_pops", pop_q.size(), 3);
    chk("n3_done_cnt", done_cnt, 1);
    chk("n3_done_after_last_pop", pops_at_done, 3);
    chk("n3_err", err_timeout_o, 1'b0);
    chk("n3_busy", busy_o, 1'b0);
    chk("n3_res_latency", lat_bad, 0);
    chk("n3_feat0", feat_q[0], 32'h0000_0000);
    chk("n3_feat1", feat_q[1], 32'h1111_1111);
    chk("n3_feat2", feat_q[2], 32'h2222_2222);
    chk("n3_res0", pop_q[0], 8'h03);
    chk("n3_res1", pop_q[1], 8'h14);
    chk("n3_res2", pop_q[2], 8'h25);

    // Zero-sample run completes without going busy.
    clear_mon();
    pulse_start(16'd0, 16'd0);
    chk("n0_done_next", done_o, 1'b1);
    step(3);
    chk("n0_done_cnt", done_cnt, 1);
    chk("n0_busy_seen", busy_seen, 1'b0);
    chk("n0_loads", load_cnt, 0);

    // Array never answers: first sample times out after 10 compute cycles.
    clear_mon();
    chip_en = 1'b0;
    pulse_start(16'd2, 16'd10);
    wait_done("to_done", 200);
    chk("to_compute_cycles", comp_cnt, 10);
    chk("to_err", err_timeout_o, 1'b1);
    chk("to_pops", pop_q.size(), 0);
    chk("to_loads", load_cnt, 1);
    chip_en = 1'b1;
    pulse_start(16'd0, 16'd0);
    chk("to_err_cleared", err_timeout_o, 1'b0);
    step(2);

    // Back-pressure: FIFO fills at 4, intake stops until readout resumes.
    clear_mon();
    bus.res_ready = 1'b0;
    pulse_start(16'd6, 16'd0);
    step(80);
    chk("bp_loads_stalled", load_cnt, 4);
    chk("bp_feat_ready", bus.feat_ready, 1'b0);
    chk("bp_res_valid", bus.res_valid, 1'b1);
    chk("bp_busy", busy_o, 1'b1);
    bus.res_ready = 1'b1;
    wait_done("bp_done", 300);
    step(1);
    chk("bp_loads", load_cnt, 6);
    chk("bp_pops", pop_q.size(), 6);
    chk("bp_done_after_last_pop", pops_at_done, 6);
    for (int k = 0; k < 6 && k < pop_q.size() && k < feat_q.size(); k++) begin
      chk($sformatf("bp_res%0d", k), pop_q[k], feat_q[k][7:0] + 8'h03);
      chk($sformatf("bp_feat%0d", k), feat_q[k][3:0], feat_q[0][3:0] + k[3:0]);
    end

    // Abort while the third sample computes with two results waiting.
    clear_mon();
    bus.res_ready = 1'b0;
    pulse_start(16'd5, 16'd0);
    wait_compute("ab_reach_compute", 3, 100);
    chk("ab_pre_res_valid", bus.res_valid, 1'b1);
    abort_i = 1'b1;
    step(1);
    abort_i = 1'b0;
    chk("ab_busy", busy_o, 1'b0);
    chk("ab_res_valid", bus.res_valid, 1'b0);
    chk("ab_aborted", aborted_o, 1'b1);
    chk("ab_done", done_o, 1'b1);
    chk("ab_compute", chip_compute_o, 1'b0);
    step(3);
    chk("ab_done_cnt", done_cnt, 1);
    bus.res_ready = 1'b1;

    // Asynchronous reset mid-compute, then a normal single-sample run.
    clear_mon();
    pulse_start(16'd2, 16'd0);
    wait_compute("rs_reach_compute", 1, 50);
    chk("rs_pre_aborted_cleared", aborted_o, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rs_compute", chip_compute_o, 1'b0);
    chk("rs_busy", busy_o, 1'b0);
    chk("rs_feat", chip_feat_o, 32'h0);
    chk("rs_res_valid", bus.res_valid, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(2);
    clear_mon();
    pulse_start(16'd1, 16'd0);
    wait_done("rs_run_done", 100);
    step(1);
    chk("rs_pops", pop_q.size(), 1);
    if (pop_q.size() > 0 && feat_q.size() > 0)
      chk("rs_res", pop_q[0], feat_q[0][7:0] + 8'h03);
    chk("rs_err", err_timeout_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
